// File: rtl/printf_arb_pkg.sv
// printf_arb_pkg: shared defaults for the printf arbiter slice.
//   NREQ_DEF  - default number of requesters
//   DW_DEF    - default payload width in bits
//   SRC_W_DEF - source-index width for the default requester count
package printf_arb_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned DW_DEF    = 128;
  localparam int unsigned SRC_W_DEF = $clog2(NREQ_DEF);

endpackage

// File: rtl/printf_arb_slot.sv
// printf_arb_slot: single-entry holding slot for one requester.
// Ports:
//   CLK, nRST  - clock, synchronous active-low reset
//   enq_ena    - enqueue strobe (ignored while full)
//   enq_data   - payload to capture
//   gnt        - slot won arbitration; empties at the next edge
//   full       - slot holds a valid entry
//   data       - held payload
module printf_arb_slot
  import printf_arb_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          enq_ena,
  input  logic [DW-1:0] enq_data,
  input  logic          gnt,
  output logic          full,
  output logic [DW-1:0] data
);

  logic          full_q, full_d;
  logic [DW-1:0] data_q, data_d;

  // A full slot is never enqueued, so load and grant are mutually exclusive.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (enq_ena && !full_q) begin
      full_d = 1'b1;
      data_d = enq_data;
    end else if (gnt) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/printf_arb.sv
// printf_arb: N-to-1 arbiter, one single-entry slot per requester feeding
// one registered output entry.
// Build option: PRINTF_ARB_RR_EN defined selects round-robin arbitration,
// otherwise fixed priority (lowest full index wins, no pointer register).
// Ports:
//   CLK, nRST       - clock, synchronous active-low reset
//   req_enq__ENA    - per-requester enqueue strobes
//   req_enq_v       - payloads, requester i at [i*DW +: DW]
//   req_enq__RDY    - per-requester ready (slot empty)
//   out_deq__ENA    - consumer dequeue strobe
//   out_deq__RDY    - output entry valid
//   out_first       - output payload
//   out_first__RDY  - same as out_deq__RDY
//   out_src         - requester index of the output entry
module printf_arb
  import printf_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned DW   = DW_DEF
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NREQ-1:0]          req_enq__ENA,
  input  logic [NREQ*DW-1:0]       req_enq_v,
  output logic [NREQ-1:0]          req_enq__RDY,
  input  logic                     out_deq__ENA,
  output logic                     out_deq__RDY,
  output logic [DW-1:0]            out_first,
  output logic                     out_first__RDY,
  output logic [$clog2(NREQ)-1:0]  out_src
);

  localparam int unsigned SRC_W = $clog2(NREQ);

  logic [NREQ-1:0]  slot_full;
  logic [DW-1:0]    slot_data [NREQ];
  logic [NREQ-1:0]  slot_gnt;

  logic             load;
  logic             gnt_vld;
  logic [SRC_W-1:0] gnt_idx;

  logic             out_full_q, out_full_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [SRC_W-1:0] out_src_q,  out_src_d;

`ifdef PRINTF_ARB_RR_EN
  logic [SRC_W-1:0] last_q, last_d;
`endif

  // Per-requester slots.
  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    printf_arb_slot #(.DW(DW)) u_slot (
      .CLK      (CLK),
      .nRST     (nRST),
      .enq_ena  (req_enq__ENA[i]),
      .enq_data (req_enq_v[i*DW +: DW]),
      .gnt      (slot_gnt[i]),
      .full     (slot_full[i]),
      .data     (slot_data[i])
    );
  end

  // Output accepts a new entry when empty or being dequeued this cycle.
  assign load = !out_full_q || out_deq__ENA;

  // Grant selection depends only on slot occupancy and the pointer.
  always_comb begin
`ifdef PRINTF_ARB_RR_EN
    int unsigned      idx;
    logic [SRC_W-1:0] cand;
`endif
    gnt_vld = 1'b0;
    gnt_idx = '0;
`ifdef PRINTF_ARB_RR_EN
    idx  = 0;
    cand = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      // Search begins just after the last winner, wrapping modulo NREQ.
      idx = 32'(last_q) + 32'd1 + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = SRC_W'(idx);
      if (!gnt_vld && slot_full[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
`else
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!gnt_vld && slot_full[SRC_W'(k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = SRC_W'(k);
      end
    end
`endif
  end

  // One-hot clear for the slot that moves into the output register.
  always_comb begin
    slot_gnt = '0;
    if (load && gnt_vld) slot_gnt[gnt_idx] = 1'b1;
  end

  // Output register next state; an empty search on a load empties the output.
  always_comb begin
    out_full_d = out_full_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
`ifdef PRINTF_ARB_RR_EN
    last_d     = last_q;
`endif
    if (load) begin
      out_full_d = gnt_vld;
      if (gnt_vld) begin
        out_data_d = slot_data[gnt_idx];
        out_src_d  = gnt_idx;
`ifdef PRINTF_ARB_RR_EN
        last_d     = gnt_idx;
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      out_full_q <= 1'b0;
      out_data_q <= '0;
      out_src_q  <= '0;
`ifdef PRINTF_ARB_RR_EN
      last_q     <= SRC_W'(NREQ - 1);
`endif
    end else begin
      out_full_q <= out_full_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
`ifdef PRINTF_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  assign req_enq__RDY   = ~slot_full;
  assign out_deq__RDY   = out_full_q;
  assign out_first__RDY = out_full_q;
  assign out_first      = out_data_q;
  assign out_src        = out_src_q;

endmodule

// File: tb/tb_printf_arb.sv
// tb_printf_arb: directed self-checking bench for printf_arb (4 x 128 bits).
module tb_printf_arb;

  logic         clk;
  logic         nrst;
  logic [3:0]   req_ena;
  logic [511:0] req_v;
  logic [3:0]   rdy;
  logic         deq_ena;
  logic         deq_rdy;
  logic [127:0] first;
  logic         first_rdy;
  logic [1:0]   src;

  int errors = 0;
  int checks = 0;

  printf_arb dut (
    .CLK            (clk),
    .nRST           (nrst),
    .req_enq__ENA   (req_ena),
    .req_enq_v      (req_v),
    .req_enq__RDY   (rdy),
    .out_deq__ENA   (deq_ena),
    .out_deq__RDY   (deq_rdy),
    .out_first      (first),
    .out_first__RDY (first_rdy),
    .out_src        (src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pay(input logic [1:0] i);
    return {96'hFACE_0000_0000_0000_0000_0000, 30'h0, i};
  endfunction

  task automatic do_reset();
    nrst    = 1'b0;
    req_ena = '0;
    deq_ena = 1'b0;
    tick();
    nrst = 1'b1;
  endtask

  task automatic drain(input string tag);
    req_ena = '0;
    for (int k = 0; k < 12 && deq_rdy; k++) begin
      deq_ena = deq_rdy;
      tick();
    end
    deq_ena = 1'b0;
    chk({tag, "_drained"}, 128'(deq_rdy), 128'd0);
  endtask

  // Requesters in mask refill as soon as ready; consumer dequeues every valid cycle.
  task automatic run_full(input string tag, input logic [3:0] mask, input logic [15:0] seq);
    logic [1:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) req_v[i*128 +: 128] = pay(2'(i));
    req_ena = mask;
    deq_ena = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      req_ena = rdy & mask;
      deq_ena = deq_rdy;
      tick();
      e = seq[k*2 +: 2];
      chk({tag, "_vld"},  128'(deq_rdy), 128'd1);
      chk({tag, "_src"},  128'(src), 128'(e));
      chk({tag, "_data"}, first, pay(e));
    end
    drain(tag);
  endtask

  initial begin
    nrst    = 1'b0;
    req_ena = '0;
    req_v   = '0;
    deq_ena = 1'b0;
    repeat (2) tick();
    nrst = 1'b1;
    tick();

    // Reset then idle.
    chk("rst_rdy",       128'(rdy), 128'hF);
    chk("rst_deq_rdy",   128'(deq_rdy), 128'd0);
    chk("rst_first_rdy", 128'(first_rdy), 128'd0);
    chk("rst_first",     first, 128'd0);
    chk("rst_src",       128'(src), 128'd0);

    // Single enqueue latency on requester 2.
    req_v[2*128 +: 128] = 128'hA5;
    req_ena = 4'b0100;
    tick();
    req_ena = '0;
    chk("lat_c1_deq_rdy", 128'(deq_rdy), 128'd0);
    chk("lat_c1_rdy",     128'(rdy), 128'hB);
    tick();
    chk("lat_c2_deq_rdy", 128'(deq_rdy), 128'd1);
    chk("lat_c2_first",   first, 128'hA5);
    chk("lat_c2_src",     128'(src), 128'd2);
    chk("lat_c2_rdy",     128'(rdy), 128'hF);
    deq_ena = 1'b1;
    tick();
    deq_ena = 1'b0;
    chk("lat_deq_empty",  128'(deq_rdy), 128'd0);

    // Output held full while slots 1 and 2 fill behind it.
    do_reset();
    for (int i = 0; i < 4; i++) req_v[i*128 +: 128] = pay(2'(i));
    req_ena = 4'b0001;
    tick();
    req_ena = '0;
    tick();
    chk("hold_src0",  128'(src), 128'd0);
    req_ena = 4'b0110;
    tick();
    req_ena = '0;
    chk("hold_rdy_a",   128'(rdy), 128'h9);
    chk("hold_first_a", first, pay(2'd0));
    tick();
    chk("hold_rdy_b",   128'(rdy), 128'h9);
    chk("hold_first_b", first, pay(2'd0));
    chk("hold_vld_b",   128'(deq_rdy), 128'd1);
    deq_ena = 1'b1;
    tick();
    chk("hold_src1",   128'(src), 128'd1);
    chk("hold_first1", first, pay(2'd1));
    chk("hold_rdy1",   128'(rdy), 128'hB);
    tick();
    chk("hold_src2",   128'(src), 128'd2);
    chk("hold_first2", first, pay(2'd2));
    chk("hold_rdy2",   128'(rdy), 128'hF);
    tick();
    deq_ena = 1'b0;
    chk("hold_empty",  128'(deq_rdy), 128'd0);

    // Reset with the output and two slots occupied.
    do_reset();
    req_ena = 4'b1000;
    tick();
    req_ena = '0;
    tick();
    chk("mrst_pre_src", 128'(src), 128'd3);
    req_ena = 4'b0011;
    tick();
    req_ena = '0;
    chk("mrst_pre_rdy", 128'(rdy), 128'hC);
    nrst = 1'b0;
    tick();
    chk("mrst_deq_rdy", 128'(deq_rdy), 128'd0);
    chk("mrst_rdy",     128'(rdy), 128'hF);
    chk("mrst_first",   first, 128'd0);
    nrst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mrst_after_vld",   128'(deq_rdy), 128'd0);
      chk("mrst_after_first", first, 128'd0);
    end

    // Requesters 0 and 3 saturating: outputs alternate 0,3 in either mode.
    run_full("pair03", 4'b1001, 16'hCCCC);

    // All four saturating.
`ifdef PRINTF_ARB_RR_EN
    run_full("all4_rr", 4'b1111, 16'hE4E4);
`else
    run_full("all4_fp", 4'b1111, 16'h4444);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/printf_arb.md
PRINTF_ARB -- requirements
Module: printf_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter DW, default 128: payload width in bits.
REQ-003 CLK  input  1  clock; all state updates on posedge CLK.
REQ-004 nRST  input  1  reset, synchronous, active-low.
REQ-005 req$enq__ENA  input  NREQ  per-requester enqueue strobe; bit i is legal only while req$enq__RDY[i]=1.
REQ-006 req$enq$v  input  NREQ*DW  payloads; requester i occupies bits [i*DW +: DW].
REQ-007 req$enq__RDY  output  NREQ  per-requester ready.
REQ-008 out$deq__ENA  input  1  consumer dequeue strobe; legal only while out$deq__RDY=1.
REQ-009 out$deq__RDY  output  1  output entry valid.
REQ-010 out$first  output  DW  payload of the output entry.
REQ-011 out$first__RDY  output  1  same value as out$deq__RDY.
REQ-012 out$src  output  clog2(NREQ)  index of the requester that supplied out$first.

Function
REQ-013 Each requester SHALL own one single-entry slot: slot_full[i] plus DW data bits.
REQ-014 req$enq__RDY[i] SHALL equal !slot_full[i] and SHALL NOT depend combinationally on any ENA input.
REQ-015 An enqueue (ENA&RDY on bit i) SHALL load slot i and set slot_full[i] at the next edge.
REQ-016 The block SHALL hold one output register: out_full, out_data, out_src.
REQ-017 The output register SHALL be loadable in a cycle when out_full=0 or out$deq__ENA=1, i.e. dequeue and reload in the same cycle.
REQ-018 When the output register is loadable and one or more slots are full, exactly one slot SHALL be granted. The granted slot's data and index SHALL move to the output register, and that slot SHALL clear at the same edge.
REQ-019 If out$deq__ENA=1 and no slot is full, out_full SHALL clear.
REQ-020 A slot SHALL NOT be enqueued and granted in the same cycle, because RDY=0 while the slot is full.
REQ-021 Throughput: each requester SHALL sustain 1 transfer per 2 cycles; the output SHALL sustain 1 transfer per cycle while any slot is full.
REQ-022 Latency: enqueue at edge t SHALL make out$deq__RDY=1 at the earliest after edge t+1 if the slot wins arbitration. Minimum latency is 2 cycles from ENA to first visible output.
REQ-023 Payload bits SHALL pass through unmodified; there is no width conversion.
REQ-024 The grant decision SHALL be combinational from slot_full and the arbitration state only, never from req$enq__ENA.

Reset
REQ-025 When nRST=0 at an edge: all slot_full=0, out_full=0, out_data=0, out_src=0, and the round-robin pointer last=NREQ-1.
REQ-026 After reset, outputs SHALL be: req$enq__RDY all ones, out$deq__RDY=0, out$first=0, out$src=0.
REQ-027 Reset mid-transfer SHALL discard every pending slot and the output entry without emitting it.

Configuration
REQ-028 Macro PRINTF_ARB_RR_EN defined: round-robin arbitration. The search starts at index last+1 mod NREQ, and last is updated to the granted index on every grant.
REQ-029 Macro PRINTF_ARB_RR_EN undefined: fixed priority, lowest full index wins. The pointer register SHALL be absent.

Structure
REQ-030 Package printf_arb_pkg SHALL hold the DW and NREQ defaults and the source-index width constant.
REQ-031 Sub-module printf_arb_slot SHALL implement one single-entry slot; printf_arb SHALL instantiate it NREQ times.

Verification
REQ-032 Reset, then idle: req$enq__RDY=4'b1111, out$deq__RDY=0, out$first=0.
REQ-033 Req 2 enqueues 128'hA5 at cycle 0, deq held 0: out$deq__RDY=1 at cycle 2 with out$first=128'hA5 and out$src=2; req$enq__RDY[2]=1 again at cycle 2.
REQ-034 RR_EN: all 4 requesters keep their slots full with deq=1 every cycle. Grant order SHALL be 0,1,2,3,0,... with no gaps at the output.
REQ-035 RR_EN undefined: requesters 0 and 3 keep their slots full. Only index 0 SHALL be output while slot 0 refills every 2 cycles; index 3 SHALL be output in the cycles where slot 0 is empty.
REQ-036 Output full with out$deq__ENA=0, then slots 1 and 2 fill: those RDY bits SHALL stay 0 and out$first SHALL stay stable. On deq=1, out$src SHALL become 1, then 2.
REQ-037 nRST=0 asserted with output and two slots full: after the reset edge out$deq__RDY=0, all RDY=1, and no stale payload appears afterwards.
